// File: rtl/dct_zigzag_quant_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dct_pkg
// Description : Shared definitions for the DCT zigzag/quantizer block:
//               coefficient width, block size, state encoding, the JPEG
//               zigzag table (index -> row*8+col) and the quantizer shift.
// Revision    : 1.0 - initial release
// ============================================================================
package dct_pkg;

   localparam int COEF_W   = 16;
   localparam int BLK_SIZE = 64;

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   // Index 0 is the leftmost entry, so the concatenation reads in zigzag order.
   localparam logic [0:63][5:0] ZZ_TABLE = {
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   // Divide by 2^s truncating toward zero: a plain arithmetic shift rounds
   // negatives toward -inf, so negatives get a (2^s - 1) bias first.
   function automatic logic signed [COEF_W-1:0] quant_shift(
      input logic signed [COEF_W-1:0] v,
      input logic        [2:0]        s
   );
      logic signed [COEF_W-1:0] bias;
      bias = v[COEF_W-1] ? ((COEF_W'(1) << s) - COEF_W'(1)) : '0;
      return (v + bias) >>> s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dct_zigzag_quant_if.sv
`default_nettype none
// ============================================================================
// Module      : dct_zigzag_quant_if
// Description : Streaming input/output handshake bundle of dct_zigzag_quant.
//               master = producer/consumer side, slave = the block itself.
// Signals     : in_valid/in_ready/in_data   - row-major coefficient input
//               out_valid/out_ready/out_data/out_idx/out_last - zigzag output
// Revision    : 1.0 - initial release
// ============================================================================
interface dct_zigzag_quant_if;

   logic                              in_valid;
   logic                              in_ready;
   logic signed [dct_pkg::COEF_W-1:0] in_data;
   logic                              out_valid;
   logic                              out_ready;
   logic signed [dct_pkg::COEF_W-1:0] out_data;
   logic        [5:0]                 out_idx;
   logic                              out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last
   );

endinterface
`default_nettype wire

// File: rtl/dct_zz_rom.sv
`default_nettype none
// ============================================================================
// Module      : dct_zz_rom
// Description : Combinational zigzag lookup, zigzag index -> {row, col}.
// Ports       : idx  in  6  zigzag index 0..63
//               row  out 3  source row
//               col  out 3  source column
// Revision    : 1.0 - initial release
// ============================================================================
module dct_zz_rom
   import dct_pkg::*;
(
   input  logic [5:0] idx,
   output logic [2:0] row,
   output logic [2:0] col
);

   logic [5:0] w_addr;

   assign w_addr = ZZ_TABLE[idx];
   assign row    = w_addr[5:3];
   assign col    = w_addr[2:0];

endmodule
`default_nettype wire

// File: rtl/dct_zigzag_quant.sv
`default_nettype none
// ============================================================================
// Module      : dct_zigzag_quant
// Description : Buffers one 8x8 block of DCT coefficients arriving in
//               row-major order, then streams it out in JPEG zigzag order
//               through a two-stage (read, output) prefetching pipeline.
//               Optional quantizer: macro DCT_ZZ_QUANT_EN divides each
//               coefficient by 2^((row+col)>>1), truncating toward zero.
// Ports       : clk    in  1  clock, rising edge
//               rst_n  in  1  asynchronous active-low reset
//               flush  in  1  synchronous abort of the current block
//               bus    slave modport of dct_zigzag_quant_if
// Revision    : 1.0 - initial release
// ============================================================================
module dct_zigzag_quant
   import dct_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   dct_zigzag_quant_if.slave        bus
);

   localparam logic [0:0] S_FILL  = FILL;
   localparam logic [0:0] S_DRAIN = DRAIN;

   logic        [COEF_W-1:0] r_mem [BLK_SIZE];
   logic        [0:0]        r_state;
   logic        [5:0]        r_wr_cnt;
   logic        [5:0]        r_rd_cnt;
   logic                     r_rd_done;

   // Read stage: holds one prefetched word so the output can run every cycle.
   logic                     r_s1_valid;
   logic signed [COEF_W-1:0] r_s1_data;
   logic        [5:0]        r_s1_idx;
`ifdef DCT_ZZ_QUANT_EN
   logic        [2:0]        r_s1_shift;
   logic        [3:0]        w_diag_sum;
`endif

   logic                     r_out_valid;
   logic signed [COEF_W-1:0] r_out_data;
   logic        [5:0]        r_out_idx;
   logic                     r_out_last;

   logic        [2:0]        w_row;
   logic        [2:0]        w_col;
   logic                     w_wr_en;
   logic                     w_out_adv;
   logic                     w_out_xfer;
   logic                     w_issue;

   dct_zz_rom u_rom (
      .idx (r_rd_cnt),
      .row (w_row),
      .col (w_col)
   );

   assign bus.in_ready  = (r_state == S_FILL);
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_idx   = r_out_idx;
   assign bus.out_last  = r_out_last;

   assign w_wr_en    = bus.in_valid && bus.in_ready && !flush;
   assign w_out_xfer = r_out_valid && bus.out_ready;
   // Output register may load when empty or when its word leaves this cycle.
   assign w_out_adv  = !r_out_valid || bus.out_ready;
   // Fetch the next zigzag element whenever the read stage has room.
   assign w_issue    = (r_state == S_DRAIN) && !r_rd_done &&
                       (!r_s1_valid || w_out_adv);

`ifdef DCT_ZZ_QUANT_EN
   assign w_diag_sum = {1'b0, w_row} + {1'b0, w_col};
`endif

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_cnt] <= bus.in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_FILL;
         r_wr_cnt    <= '0;
         r_rd_cnt    <= '0;
         r_rd_done   <= 1'b0;
         r_s1_valid  <= 1'b0;
         r_s1_data   <= '0;
         r_s1_idx    <= '0;
`ifdef DCT_ZZ_QUANT_EN
         r_s1_shift  <= '0;
`endif
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_out_last  <= 1'b0;
      end else if (flush) begin
         r_state     <= S_FILL;
         r_wr_cnt    <= '0;
         r_rd_cnt    <= '0;
         r_rd_done   <= 1'b0;
         r_s1_valid  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wr_cnt <= r_wr_cnt + 6'd1;
            if (r_wr_cnt == 6'd63) begin
               r_state <= S_DRAIN;
            end
         end

         if (w_issue) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= r_mem[{w_row, w_col}];
            r_s1_idx   <= r_rd_cnt;
`ifdef DCT_ZZ_QUANT_EN
            r_s1_shift <= 3'(w_diag_sum >> 1);
`endif
            r_rd_cnt   <= r_rd_cnt + 6'd1;
            if (r_rd_cnt == 6'd63) begin
               r_rd_done <= 1'b1;
            end
         end else if (w_out_adv) begin
            r_s1_valid <= 1'b0;
         end

         if (w_out_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
`ifdef DCT_ZZ_QUANT_EN
               r_out_data <= quant_shift(r_s1_data, r_s1_shift);
`else
               r_out_data <= r_s1_data;
`endif
               r_out_idx  <= r_s1_idx;
               r_out_last <= (r_s1_idx == 6'd63);
            end
         end

         // Final word accepted: the read stage is already empty here.
         if (w_out_xfer && r_out_last) begin
            r_state   <= S_FILL;
            r_rd_done <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dct_zigzag_quant.sv
`default_nettype none
// ============================================================================
// Module      : tb_dct_zigzag_quant
// Description : Directed self-checking bench for dct_zigzag_quant. Expected
//               outputs come from an independent zigzag table and a
//               divide-based quantizer model (enabled with DCT_ZZ_QUANT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dct_zigzag_quant;

   logic clk;
   logic rst_n;
   logic flush;

   dct_zigzag_quant_if bus ();

   dct_zigzag_quant dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   int zz[64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

   int blk[64];
   int exp_val[64];
   int obs_val[64];

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] expv);
      n_total = n_total + 1;
      assert (obs === expv) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
   endtask

   task automatic build_exp();
      int a;
      int s;
      for (int k = 0; k < 64; k++) begin
         a = zz[k];
         s = ((a / 8) + (a % 8)) / 2;
`ifdef DCT_ZZ_QUANT_EN
         exp_val[k] = blk[a] / (1 << s);
`else
         exp_val[k] = blk[a] + 0 * s;
`endif
      end
   endtask

   task automatic write_words(input int n);
      for (int i = 0; i < n; i++) begin
         if (i == 0) check("wr_ready", bus.in_ready, 1);
         bus.in_valid = 1'b1;
         bus.in_data  = 16'(blk[i]);
         @(posedge clk); @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   // mode bit0: out_ready pattern 1,0,0,1; bit1: junk on the input during drain
   task automatic drain(input int mode);
      int  k;
      int  cyc;
      logic rdy;
      k = 0;
      cyc = 0;
      while (k < 64 && cyc < 1000) begin
         rdy = ((mode & 1) != 0) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         bus.out_ready = rdy;
         if ((mode & 2) != 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'($urandom);
         end
         if ((mode & 1) == 0 && k > 0) check("b2b_valid", bus.out_valid, 1);
         if (bus.out_valid) begin
            check("idx", bus.out_idx, k);
            check("data", $signed(bus.out_data), exp_val[k]);
            check("last", bus.out_last, (k == 63) ? 1 : 0);
            obs_val[k] = $signed(bus.out_data);
            if (rdy) k++;
         end
         @(posedge clk); @(negedge clk);
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("drain_count", k, 64);
      check("post_in_ready", bus.in_ready, 1);
      check("post_out_valid", bus.out_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      rst_n         = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_idx", bus.out_idx, 0);
      check("rst_out_last", bus.out_last, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);

      // Ramp block with explicit latency check
      for (int i = 0; i < 64; i++) blk[i] = i;
      build_exp();
      write_words(64);
      check("drain_in_ready", bus.in_ready, 0);
      check("lat_e0_valid", bus.out_valid, 0);
      @(posedge clk); @(negedge clk);
      check("lat_e1_valid", bus.out_valid, 0);
      @(posedge clk); @(negedge clk);
      check("lat_e2_valid", bus.out_valid, 1);
      drain(0);

      // Quantizer examples
      for (int i = 0; i < 64; i++) blk[i] = ((i * 37) % 200) - 100;
      blk[63] = -300;
      blk[1]  = 5;
      blk[9]  = -3;
      blk[56] = -32767;
      build_exp();
      write_words(64);
      drain(0);
`ifdef DCT_ZZ_QUANT_EN
      check("q_77", obs_val[63], -2);
      check("q_01", obs_val[1], 5);
      check("q_11", obs_val[4], -1);
`else
      check("q_77", obs_val[63], -300);
      check("q_01", obs_val[1], 5);
      check("q_11", obs_val[4], -3);
`endif

      // Stalling consumer
      for (int i = 0; i < 64; i++) blk[i] = i * 11 - 350;
      build_exp();
      write_words(64);
      drain(1);

      // Flush after 40 writes, accepting write in the flush cycle dropped
      for (int i = 0; i < 64; i++) blk[i] = 1000 + i;
      write_words(40);
      flush        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd7777;
      @(posedge clk); @(negedge clk);
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_in_ready", bus.in_ready, 1);
      check("flush_out_valid", bus.out_valid, 0);
      for (int i = 0; i < 64; i++) blk[i] = 2000 - i * 3;
      build_exp();
      write_words(64);
      drain(0);

      // Flush in the middle of a drain
      for (int i = 0; i < 64; i++) blk[i] = -(i * 5);
      write_words(64);
      repeat (6) @(negedge clk);
      flush = 1'b1;
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      check("dflush_out_valid", bus.out_valid, 0);
      check("dflush_in_ready", bus.in_ready, 1);
      for (int i = 0; i < 64; i++) blk[i] = i * 7 - 200;
      build_exp();
      write_words(64);
      drain(0);

      // Asynchronous reset mid-drain at out_idx 20
      for (int i = 0; i < 64; i++) blk[i] = 500 - i;
      write_words(64);
      cyc = 0;
      while (!(bus.out_valid && bus.out_idx == 6'd20) && cyc < 300) begin
         @(posedge clk); @(negedge clk);
         cyc++;
      end
      check("reach_idx20", bus.out_idx, 20);
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", bus.out_valid, 0);
      check("arst_out_idx", bus.out_idx, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("arst_in_ready", bus.in_ready, 1);
      for (int i = 0; i < 64; i++) blk[i] = i * 13 - 400;
      build_exp();
      write_words(64);
      drain(0);

      // Input activity during drain is ignored
      for (int i = 0; i < 64; i++) blk[i] = 300 - i * 9;
      build_exp();
      write_words(64);
      drain(2);
      write_words(64);
      drain(0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dct_zigzag_quant.md
DCT_ZIGZAG_QUANT -- requirements
Module: dct_zigzag_quant

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset; assertion takes effect immediately, deassertion is synchronous to clk.
REQ-003 flush  in  1  synchronous abort of the current block.
REQ-004 in_valid  in  1  coefficient present on in_data.
REQ-005 in_ready  out  1  block accepts a coefficient this cycle.
REQ-006 in_data  in  16  signed 2's-complement DCT coefficient, row-major order (row 0 col 0..7, row 1 ...).
REQ-007 out_valid  out  1  out_data/out_idx/out_last valid.
REQ-008 out_ready  in  1  consumer accepts the current output.
REQ-009 out_data  out  16  signed coefficient in zigzag order, quantized when the quantizer is compiled in.
REQ-010 out_idx  out  6  zigzag index 0..63 of out_data.
REQ-011 out_last  out  1  high with out_idx==63.

Function
REQ-012 Two states: FILL and DRAIN; 64x16 storage; 6-bit write counter wr_cnt; 6-bit zigzag counter rd_cnt.
REQ-013 FILL: in_ready=1, out_valid=0; on in_valid&&in_ready the word is written at address wr_cnt and wr_cnt increments.
REQ-014 The write with wr_cnt==63 moves the state to DRAIN on the next edge; wr_cnt wraps to 0.
REQ-015 DRAIN: in_ready=0; storage address = ZZ[rd_cnt], where ZZ is the standard JPEG zigzag table mapping index to row*8+col.
REQ-016 Output registered: out_valid rises exactly 2 cycles after the edge entering DRAIN (one cycle storage read, one cycle output register); first output is out_idx=0 = element (0,0).
REQ-017 Output transfer occurs on out_valid&&out_ready; out_data/out_idx/out_last SHALL hold stable while out_valid&&!out_ready.
REQ-018 Back-to-back transfers at one per cycle SHALL be sustained while out_ready stays high (read pipeline prefetches).
REQ-019 Transfer with out_last=1 returns state to FILL on the next edge, with in_ready=1 and out_valid=0 in that cycle; rd_cnt wraps to 0.
REQ-020 flush has priority over any handshake in the same cycle: next edge gives state FILL, wr_cnt=rd_cnt=0, out_valid=0; the accepting write/transfer of that cycle is discarded; storage contents are not cleared.
REQ-021 in_valid during DRAIN is ignored (no write, no error).

Reset
REQ-022 On rst_n=0: state FILL, wr_cnt=0, rd_cnt=0, in_ready=1 once reset deasserts, out_valid=0, out_data=0, out_idx=0, out_last=0; storage not reset.
REQ-023 Reset mid-block discards the partial block; the next accepted input is element (0,0).

Configuration
REQ-024 Macro DCT_ZZ_QUANT_EN defined: out_data = stored value divided by 2^s, truncating toward zero, s = (row+col)>>1 of the source element (s in 0..7); implemented as add (2^s-1) when negative, then arithmetic shift right by s.
REQ-025 Macro DCT_ZZ_QUANT_EN undefined: out_data = stored value unchanged; latency and handshake identical.

Structure
REQ-026 Shared package dct_pkg holds: coefficient width (16), block size (64), state enum {FILL, DRAIN}, and the 64-entry zigzag table.
REQ-027 One sub-module dct_zz_rom: combinational index -> {row,col} lookup; quantizer shift logic stays inline.

Verification
REQ-028 Write 0..63 (value = address), out_ready=1 -> outputs 0,1,8,16,9,2,3,10,... (quant off); out_last with value 63; in_ready=1 the cycle after.
REQ-029 Quant on: element (7,7) = -300 -> s=7 -> out_data=-2; element (0,1) = 5 -> s=0 -> 5; element (1,1) = -3 -> s=1 -> -1.
REQ-030 DRAIN with out_ready toggling 1,0,0,1 -> each index appears once, values stable during stalls, no skip or duplicate.
REQ-031 flush asserted after 40 writes -> next 64 writes form a fresh block; first output equals 41st-from-reset-of-block write, i.e. new (0,0).
REQ-032 rst_n pulsed low mid-DRAIN at out_idx=20 -> out_valid=0 immediately; in_ready=1 after release; next block drains from index 0.
REQ-033 in_valid held high through DRAIN with changing data -> drained values unaffected.
